// File: rtl/sim_network_pkg.sv
// Shared definitions for the simulated NIC network egress path.
//   NET_IF_WIDTH / NET_KEEP_WIDTH : native link flit and byte-enable widths
//   RLIMIT_*_DEF                  : suggested rate-limiter programming values
//   arb_state_e                   : packet arbiter states
package sim_network_pkg;

  localparam int NET_IF_WIDTH   = 64;
  localparam int NET_KEEP_WIDTH = 8;

  localparam int RLIMIT_INC_DEF    = 1;
  localparam int RLIMIT_PERIOD_DEF = 1;
  localparam int RLIMIT_SIZE_DEF   = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_e;

endpackage

// File: rtl/sim_network_tx_mux_fifo.sv
// net_flit_fifo: single-clock flit FIFO used once per egress channel.
//   clock, reset : clock and asynchronous active-high reset (empties the FIFO)
//   push, wdata  : write strobe and flit {data, keep, last}; ignored when full
//   pop, rdata   : read strobe and head flit; pop ignored when empty
//   full, empty  : occupancy flags
module net_flit_fifo #(
  parameter int WIDTH = 73,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/sim_network_tx_mux.sv
// sim_network_tx_mux: rate-limited, packet-granular round-robin egress mux.
// Buffers NUM_CH flit streams, grants one channel per packet and paces the
// output link with a token bucket.
//   clock, reset          : clock, asynchronous active-high reset
//   in_valid/ready/data/keep/last : per-channel input flit streams (packed by channel)
//   out_valid/ready/data/keep/last: output link
//   out_chan              : source channel of the presented flit
//   rlimit_inc            : tokens added per refill
//   rlimit_period         : refill every rlimit_period+1 cycles
//   rlimit_size           : bucket cap, 0 bypasses the limiter
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ARB_IDLE  | no grant; pick next non-empty channel from rr_ptr (one bubble)
// ARB_BURST | forward packet of channel grant until its last flit fires
module sim_network_tx_mux
  import sim_network_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = NET_IF_WIDTH,
  parameter int KEEP_W     = DATA_W / 8,
  parameter int FIFO_DEPTH = 8,
  parameter int RLIMIT_W   = 8,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          in_valid,
  output logic [NUM_CH-1:0]          in_ready,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  input  logic [NUM_CH*KEEP_W-1:0]   in_keep,
  input  logic [NUM_CH-1:0]          in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [KEEP_W-1:0]          out_keep,
  output logic                       out_last,
  output logic [CH_W-1:0]            out_chan,
  input  logic [RLIMIT_W-1:0]        rlimit_inc,
  input  logic [RLIMIT_W-1:0]        rlimit_period,
  input  logic [RLIMIT_W-1:0]        rlimit_size
);

  localparam int FLIT_W = DATA_W + KEEP_W + 1;

  // (base + off) mod NUM_CH, with off < NUM_CH
  function automatic logic [CH_W-1:0] ch_add(input logic [CH_W-1:0] base,
                                             input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  arb_state_e            state_q, state_d;
  logic [CH_W-1:0]       grant_q, grant_d;
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [RLIMIT_W-1:0]   tokens_q, tokens_d;
  logic [RLIMIT_W-1:0]   period_cnt_q, period_cnt_d;

  logic [NUM_CH-1:0]     full, empty, push, pop;
  logic [FLIT_W-1:0]     head [NUM_CH];
  logic [FLIT_W-1:0]     head_sel;

  logic                  fire, bypass, refill, consume;
  logic                  pick_found;
  logic [CH_W-1:0]       pick_ch;
  logic [CH_W-1:0]       cand;
  logic [RLIMIT_W+1:0]   tok_sum;

  // ---------------------------------------------------------------- FIFOs
  assign in_ready = ~full & {NUM_CH{~reset}};
  assign push     = in_valid & in_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign pop[g] = fire && (grant_q == CH_W'(g));

    net_flit_fifo #(
      .WIDTH (FLIT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push[g]),
      .wdata ({in_data[g*DATA_W +: DATA_W], in_keep[g*KEEP_W +: KEEP_W], in_last[g]}),
      .pop   (pop[g]),
      .rdata (head[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  // --------------------------------------------------------- token bucket
  assign bypass  = (rlimit_size == '0);
  assign consume = fire && !bypass;

  always_comb begin
    // >= rather than == so a live reduction of rlimit_period cannot strand
    // the counter above the new terminal value.
    refill       = (period_cnt_q >= rlimit_period);
    period_cnt_d = refill ? '0 : period_cnt_q + 1'b1;
    // Two guard bits: the sum cannot overflow and consume never underflows
    // because fire requires tokens >= 1.
    tok_sum = {2'b00, tokens_q}
            + (refill ? {2'b00, rlimit_inc} : '0)
            - {{(RLIMIT_W+1){1'b0}}, consume};
    if (tok_sum > {2'b00, rlimit_size}) begin
      tokens_d = rlimit_size;
    end else begin
      tokens_d = tok_sum[RLIMIT_W-1:0];
    end
  end

  // ------------------------------------------------------- state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      tokens_q     <= '0;
      period_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      tokens_q     <= tokens_d;
      period_cnt_q <= period_cnt_d;
    end
  end

  // ---------------------------------------------------- next-state logic
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    cand       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = ch_add(rr_ptr_q, i);
      if (!pick_found && !empty[cand]) begin
        pick_found = 1'b1;
        pick_ch    = cand;
      end
    end

    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d = pick_ch;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        // Grant is held even if the FIFO runs dry mid-packet.
        if (fire && out_last) begin
          rr_ptr_d = ch_add(grant_q, 1);
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // --------------------------------------------------------- output logic
  always_comb begin
    head_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_q == CH_W'(c)) head_sel = head[c];
    end

    out_valid = 1'b0;
    out_data  = '0;
    out_keep  = '0;
    out_last  = 1'b0;
    out_chan  = '0;
    if (state_q == ARB_BURST) begin
      out_valid = !empty[grant_q] && (bypass || (tokens_q != '0));
      out_data  = head_sel[FLIT_W-1 -: DATA_W];
      out_keep  = head_sel[KEEP_W:1];
      out_last  = head_sel[0];
      out_chan  = grant_q;
    end
  end

  assign fire = out_valid && out_ready;

endmodule

// File: tb/tb_sim_network_tx_mux.sv
module tb_sim_network_tx_mux;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam int RLW    = 8;

  logic                      clock;
  logic                      reset;
  logic [NUM_CH-1:0]         in_valid;
  logic [NUM_CH-1:0]         in_ready;
  logic [NUM_CH*DATA_W-1:0]  in_data;
  logic [NUM_CH*KEEP_W-1:0]  in_keep;
  logic [NUM_CH-1:0]         in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [KEEP_W-1:0]         out_keep;
  logic                      out_last;
  logic [1:0]                out_chan;
  logic [RLW-1:0]            rlimit_inc;
  logic [RLW-1:0]            rlimit_period;
  logic [RLW-1:0]            rlimit_size;

  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [KEEP_W-1:0] ch_keep [NUM_CH];

  int n_checks = 0;
  int n_errors = 0;

  sim_network_tx_mux dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_keep       (in_keep),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_keep      (out_keep),
    .out_last      (out_last),
    .out_chan      (out_chan),
    .rlimit_inc    (rlimit_inc),
    .rlimit_period (rlimit_period),
    .rlimit_size   (rlimit_size)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    in_data = '0;
    in_keep = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      in_data[c*DATA_W +: DATA_W] = ch_data[c];
      in_keep[c*KEEP_W +: KEEP_W] = ch_keep[c];
    end
  end

  function automatic logic [DATA_W-1:0] mk_data(input int c, input logic [7:0] tag);
    return {8'hC0 | 8'(c), 48'h0, tag};
  endfunction

  function automatic logic [KEEP_W-1:0] mk_keep(input logic [7:0] tag);
    return ~tag;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] vld, input logic [3:0] lst, input logic [7:0] tag);
    for (int c = 0; c < NUM_CH; c++) begin
      in_valid[c] = vld[c];
      in_last[c]  = lst[c];
      ch_data[c]  = mk_data(c, tag);
      ch_keep[c]  = mk_keep(tag);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset held across one edge; returns at the start of cycle 0.
  task automatic do_reset();
    reset = 1'b1;
    drive(4'b0, 4'b0, 8'h0);
    tick();
    reset = 1'b0;
  endtask

  // Expected output of one flit as a single comparable word.
  function automatic logic [127:0] exp_flit(input int c, input logic [7:0] tag, input logic lst);
    return 128'({1'b1, 2'(c), mk_data(c, tag), mk_keep(tag), lst});
  endfunction

  function automatic logic [127:0] act_flit();
    return 128'({out_valid, out_chan, out_data, out_keep, out_last});
  endfunction

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] lst;
    logic [7:0] tag;
    logic       ev;
    logic [1:0] ech;
    logic [7:0] etag;
    logic       el;
  } vec_t;

  function automatic vec_t mkv(input logic rst, input logic [3:0] vld, input logic [3:0] lst,
                               input logic [7:0] tag, input logic ev, input logic [1:0] ech,
                               input logic [7:0] etag, input logic el);
    vec_t v;
    v.rst = rst; v.vld = vld; v.lst = lst; v.tag = tag;
    v.ev = ev; v.ech = ech; v.etag = etag; v.el = el;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [20];
    logic       fire;
    logic       acc;
    logic       exp_fire;
    int         tag_in;
    int         exp_tag;
    int         got;

    reset         = 1'b1;
    out_ready     = 1'b1;
    rlimit_inc    = '0;
    rlimit_period = '0;
    rlimit_size   = '0;
    drive(4'b0, 4'b0, 8'h0);

    // Bypass: 3-flit ch0 packet, then ch0+ch2 4-flit packets together.
    tbl[0]  = mkv(1, 4'b0000, 4'b0000, 8'h00, 0, 0, 8'h00, 0);
    tbl[1]  = mkv(0, 4'b0001, 4'b0000, 8'hA0, 0, 0, 8'h00, 0);
    tbl[2]  = mkv(0, 4'b0001, 4'b0000, 8'hA1, 0, 0, 8'h00, 0);
    tbl[3]  = mkv(0, 4'b0001, 4'b0001, 8'hA2, 1, 0, 8'hA0, 0);
    tbl[4]  = mkv(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 8'hA1, 0);
    tbl[5]  = mkv(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 8'hA2, 1);
    tbl[6]  = mkv(0, 4'b0000, 4'b0000, 8'h00, 0, 0, 8'h00, 0);
    tbl[7]  = mkv(1, 4'b0000, 4'b0000, 8'h00, 0, 0, 8'h00, 0);
    tbl[8]  = mkv(0, 4'b0101, 4'b0000, 8'hB0, 0, 0, 8'h00, 0);
    tbl[9]  = mkv(0, 4'b0101, 4'b0000, 8'hB1, 0, 0, 8'h00, 0);
    tbl[10] = mkv(0, 4'b0101, 4'b0000, 8'hB2, 1, 0, 8'hB0, 0);
    tbl[11] = mkv(0, 4'b0101, 4'b0101, 8'hB3, 1, 0, 8'hB1, 0);
    tbl[12] = mkv(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 8'hB2, 0);
    tbl[13] = mkv(0, 4'b0000, 4'b0000, 8'h00, 1, 0, 8'hB3, 1);
    tbl[14] = mkv(0, 4'b0000, 4'b0000, 8'h00, 0, 0, 8'h00, 0);
    tbl[15] = mkv(0, 4'b0000, 4'b0000, 8'h00, 1, 2, 8'hB0, 0);
    tbl[16] = mkv(0, 4'b0000, 4'b0000, 8'h00, 1, 2, 8'hB1, 0);
    tbl[17] = mkv(0, 4'b0000, 4'b0000, 8'h00, 1, 2, 8'hB2, 0);
    tbl[18] = mkv(0, 4'b0000, 4'b0000, 8'h00, 1, 2, 8'hB3, 1);
    tbl[19] = mkv(0, 4'b0000, 4'b0000, 8'h00, 0, 0, 8'h00, 0);

    tick();
    for (int i = 0; i < 20; i++) begin
      reset = tbl[i].rst;
      drive(tbl[i].vld, tbl[i].lst, tbl[i].tag);
      #1;
      if (tbl[i].ev) begin
        chk($sformatf("tbl[%0d] flit", i), act_flit(),
            exp_flit(int'(tbl[i].ech), tbl[i].etag, tbl[i].el));
      end else begin
        chk($sformatf("tbl[%0d] out_valid", i), 128'(out_valid), 128'(1'b0));
      end
      if (tbl[i].rst) begin
        chk($sformatf("tbl[%0d] reset outputs", i), act_flit(), 128'(0));
        chk($sformatf("tbl[%0d] reset in_ready", i), 128'(in_ready), 128'(4'b0000));
      end
      @(posedge clock);
      #1;
    end
    chk("rr_ptr after ch0/ch2", 128'(dut.rr_ptr_q), 128'(2'd3));

    // Rate limit: inc=1, period=3, size=2, ch1 saturated from cycle 10.
    do_reset();
    rlimit_inc = 8'd1; rlimit_period = 8'd3; rlimit_size = 8'd2;
    out_ready = 1'b1;
    tag_in = 0; exp_tag = 0;
    for (int k = 0; k < 52; k++) begin
      drive((k >= 10) ? 4'b0010 : 4'b0000, 4'b0000, 8'(tag_in));
      #1;
      fire     = out_valid & out_ready;
      exp_fire = (k == 12) || (k == 13) || ((k >= 16) && (k % 4 == 0));
      chk($sformatf("rate fire k=%0d", k), 128'(fire), 128'(exp_fire));
      if (fire) begin
        chk($sformatf("rate flit k=%0d", k), act_flit(), exp_flit(1, 8'(exp_tag), 1'b0));
        exp_tag++;
      end
      if (dut.tokens_q > 8'd2) begin
        chk($sformatf("rate token cap k=%0d", k), 128'(dut.tokens_q), 128'(8'd2));
      end
      if (k == 11) chk("rate idle fill", 128'(dut.tokens_q), 128'(8'd2));
      acc = in_valid[1] & in_ready[1];
      tick();
      if (acc) tag_in++;
    end

    // Backpressure: 9 flits into a depth-8 FIFO with out_ready low.
    do_reset();
    rlimit_size = 8'd0;
    out_ready = 1'b0;
    tag_in = 0;
    for (int k = 0; k < 12; k++) begin
      drive((tag_in <= 8) ? 4'b0010 : 4'b0000, (tag_in == 8) ? 4'b0010 : 4'b0000, 8'(tag_in));
      #1;
      chk($sformatf("bp in_ready k=%0d", k), 128'(in_ready[1]), 128'(k < 8));
      acc = in_valid[1] & in_ready[1];
      tick();
      if (acc) tag_in++;
    end
    chk("bp holding head", act_flit(), exp_flit(1, 8'h00, 1'b0));
    out_ready = 1'b1;
    exp_tag = 0; got = 0;
    for (int k = 0; k < 30; k++) begin
      drive((tag_in <= 8) ? 4'b0010 : 4'b0000, (tag_in == 8) ? 4'b0010 : 4'b0000, 8'(tag_in));
      #1;
      fire = out_valid & out_ready;
      acc  = in_valid[1] & in_ready[1];
      if (fire) begin
        chk($sformatf("bp drain flit %0d", exp_tag), act_flit(),
            exp_flit(1, 8'(exp_tag), exp_tag == 8));
        exp_tag++;
        got++;
      end
      tick();
      if (acc) tag_in++;
    end
    chk("bp flits drained", 128'(got), 128'(9));

    // Saturated bucket with refill every cycle and continuous fire.
    do_reset();
    rlimit_inc = 8'd1; rlimit_period = 8'd0; rlimit_size = 8'd4;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    #1;
    chk("full bucket", 128'(dut.tokens_q), 128'(8'd4));
    tag_in = 0; exp_tag = 0;
    for (int k = 0; k < 24; k++) begin
      drive(4'b0001, 4'b0000, 8'(tag_in));
      #1;
      if (k >= 2) begin
        chk($sformatf("sat flit k=%0d", k), act_flit(), exp_flit(0, 8'(exp_tag), 1'b0));
        chk($sformatf("sat tokens k=%0d", k), 128'(dut.tokens_q), 128'(8'd4));
        exp_tag++;
      end
      acc = in_valid[0] & in_ready[0];
      tick();
      if (acc) tag_in++;
    end

    // Reset in the middle of a packet, then a clean ch3 packet.
    do_reset();
    rlimit_inc = 8'd1; rlimit_period = 8'd0; rlimit_size = 8'd8;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(4'b0001, (k == 3) ? 4'b0001 : 4'b0000, 8'(8'h60 + k));
      tick();
    end
    drive(4'b0, 4'b0, 8'h0);
    #1;
    chk("mid pkt before reset", act_flit(), exp_flit(0, 8'h62, 1'b0));
    chk("mid pkt tokens", 128'(dut.tokens_q), 128'(8'd2));
    reset = 1'b1;
    #1;
    chk("async reset out", act_flit(), 128'(0));
    chk("async reset tokens", 128'(dut.tokens_q), 128'(0));
    chk("async reset in_ready", 128'(in_ready), 128'(0));
    tick();
    reset = 1'b0;
    chk("rr_ptr after reset", 128'(dut.rr_ptr_q), 128'(0));
    for (int k = 0; k < 8; k++) begin
      drive((k < 2) ? 4'b1000 : 4'b0000, (k == 1) ? 4'b1000 : 4'b0000, 8'(8'h70 + k));
      #1;
      if (k == 2) chk("post reset flit0", act_flit(), exp_flit(3, 8'h70, 1'b0));
      else if (k == 3) chk("post reset flit1", act_flit(), exp_flit(3, 8'h71, 1'b1));
      else chk($sformatf("post reset idle k=%0d", k), 128'(out_valid), 128'(0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
